gf180mcu_ocd_io__pwr_seq: RTL and testbench

//  Power-up sequencer for the pad ring. Consumes the supply-good flags of the

---
 rtl/gf180mcu_ocd_io__pwr_seq.sv | 106 ++++++++++
 tb/tb_gf180mcu_ocd_io__pwr_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// Pad-ring power-up sequencer: debounces the pad and core supply-good flags,
// releases pad output enable and then core reset, and latches a fault on supply loss.
module gf180mcu_ocd_io__pwr_seq #(
  parameter int DEB_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dvdd_ok,
  input  logic       vdd_ok,
  input  logic       clr,
  output logic       io_oe_en,
  output logic       core_rstn,
  output logic       pwr_good,
  output logic       fault,
  output logic [2:0] state
);

  localparam int MAX_CYCLES = (DEB_CYCLES > SETTLE_CYCLES) ? DEB_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DEB_D = 3'd1,
    ST_DEB_V = 3'd2,
    ST_IO_EN = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             dvdd_m, dvdd_s, vdd_m, vdd_s;
  logic             supply_lost;

  // Supply flags arrive asynchronously from the ring detectors, so each passes a 2-flop synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      dvdd_m  <= 1'b0;
      dvdd_s  <= 1'b0;
      vdd_m   <= 1'b0;
      vdd_s   <= 1'b0;
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      dvdd_m  <= dvdd_ok;
      dvdd_s  <= dvdd_m;
      vdd_m   <= vdd_ok;
      vdd_s   <= vdd_m;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign supply_lost = !dvdd_s || !vdd_s;

  // Timer defaults to zero, so any state change or non-counting state clears it
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    io_oe_en  = 1'b0;
    core_rstn = 1'b0;
    pwr_good  = 1'b0;
    fault     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dvdd_s) state_d = ST_DEB_D;
      end
      ST_DEB_D: begin
        if (!dvdd_s)                state_d = ST_IDLE;
        else if (timer_q == DEB_LAST) state_d = ST_DEB_V;
        else                        timer_d = timer_inc;
      end
      ST_DEB_V: begin
        if (!dvdd_s)                  state_d = ST_IDLE;
        else if (!vdd_s)              timer_d = '0;
        else if (timer_q == DEB_LAST) state_d = ST_IO_EN;
        else                          timer_d = timer_inc;
      end
      ST_IO_EN: begin
        io_oe_en = 1'b1;
        if (supply_lost)                 state_d = ST_FAULT;
        else if (timer_q == SETTLE_LAST) state_d = ST_RUN;
        else                             timer_d = timer_inc;
      end
      ST_RUN: begin
        io_oe_en  = 1'b1;
        core_rstn = 1'b1;
        pwr_good  = 1'b1;
        if (supply_lost) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        fault = 1'b1;
        if (clr && !dvdd_s && !vdd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io__pwr_seq.sv
// Randomized scoreboard bench for the pad-ring power sequencer, checked
// against an elapsed-time reference model of the sequencing rules.
module tb_gf180mcu_ocd_io__pwr_seq;

  localparam int DEB    = 4;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       rst, dvdd_ok, vdd_ok, clr;
  logic       io_oe_en, core_rstn, pwr_good, fault;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       io;
    logic       rstn;
    logic       pg;
    logic       flt;
  } obs_t;

  obs_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: phase number, edge it was entered on, synced-flag pipeline
  int   edgeNum = 0;
  int   phase   = 0;
  int   entered = 0;
  int   vRun    = 0;
  logic d1 = 0, d2 = 0, v1 = 0, v2 = 0;

  gf180mcu_ocd_io__pwr_seq #(
    .DEB_CYCLES   (DEB),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dvdd_ok  (dvdd_ok),
    .vdd_ok   (vdd_ok),
    .clr      (clr),
    .io_oe_en (io_oe_en),
    .core_rstn(core_rstn),
    .pwr_good (pwr_good),
    .fault    (fault),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic void enterPhase(input int p);
    phase   = p;
    entered = edgeNum;
    vRun    = 0;
  endfunction

  function automatic obs_t modelStep(input logic r, input logic d, input logic v, input logic c);
    obs_t o;
    logic sd, sv;
    edgeNum++;
    if (r) begin
      d1 = 0; d2 = 0; v1 = 0; v2 = 0;
      enterPhase(0);
    end else begin
      sd = d2;
      sv = v2;
      case (phase)
        0: if (sd) enterPhase(1);
        1: begin
          if (!sd) enterPhase(0);
          else if (edgeNum - entered == DEB) enterPhase(2);
        end
        2: begin
          if (!sd) enterPhase(0);
          else if (!sv) vRun = 0;
          else begin
            vRun++;
            if (vRun == DEB) enterPhase(3);
          end
        end
        3: begin
          if (!sd || !sv) enterPhase(5);
          else if (edgeNum - entered == SETTLE) enterPhase(4);
        end
        4: if (!sd || !sv) enterPhase(5);
        default: if (c && !sd && !sv) enterPhase(0);
      endcase
      d2 = d1; d1 = d;
      v2 = v1; v1 = v;
    end
    o.st   = 3'(phase);
    o.io   = (phase == 3) || (phase == 4);
    o.rstn = (phase == 4);
    o.pg   = (phase == 4);
    o.flt  = (phase == 5);
    return o;
  endfunction

  task automatic applyStimulus(input logic r, input logic d, input logic v, input logic c);
    rst = r; dvdd_ok = d; vdd_ok = v; clr = c;
    @(posedge clk);
    expq.push_back(modelStep(r, d, v, c));
    #1;
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = '{st: state, io: io_oe_en, rstn: core_rstn, pg: pwr_good, flt: fault};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL outputs edge~%0d: got state=%0d io=%b rstn=%b pg=%b fault=%b, expected state=%0d io=%b rstn=%b pg=%b fault=%b",
               edgeNum, a.st, a.io, a.rstn, a.pg, a.flt, e.st, e.io, e.rstn, e.pg, e.flt);
    end
  endtask

  // Monitor: one registered output set per cycle, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    logic d, v;
    rst = 1'b1; dvdd_ok = 1'b0; vdd_ok = 1'b0; clr = 1'b0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    $display("[TB] full power-up sequence");
    for (int i = 0; i < 24; i++) applyStimulus(0, 1, 1, 0);

    $display("[TB] core supply loss in RUN, then clear attempts");
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] pad supply glitch during debounce");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 1, 1, 0);

    $display("[TB] supply loss coinciding with settle expiry");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 1, (i == 16) ? 1'b0 : 1'b1, 0);

    $display("[TB] reset in RUN with supplies held");
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 22; i++) applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    for (int i = 0; i < 24; i++) applyStimulus(0, 1, 1, 0);

    $display("[TB] randomized supply activity");
    d = 1'b1; v = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (d) d = ($urandom_range(49) != 0); else d = ($urandom_range(3) == 0);
      if (v) v = ($urandom_range(49) != 0); else v = ($urandom_range(3) == 0);
      if (phase == 5 && $urandom_range(5) == 0) begin
        d = 1'b0; v = 1'b0;
      end
      applyStimulus($urandom_range(199) == 0, d, v, $urandom_range(3) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
